// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and mode constants for the SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period divider with leading/trailing edge strobes
module spi_clk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic cpol_i,
    input  logic en_i,
    output logic sclk_o,
    output logic lead_edge_o,
    output logic trail_edge_o,
    output logic last_edge_o
);

    localparam int HP_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [HP_W-1:0]   HP_LAST   = HP_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    logic [HP_W-1:0]   hp_cnt_q, hp_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d;
    logic              tc;

    // A toggle happens when the half-period counter reaches its terminal count.
    // Toggle number edge_cnt_q+1 is odd (leading) when edge_cnt_q is even.
    assign tc           = en_i && (hp_cnt_q == HP_LAST);
    assign lead_edge_o  = tc && !edge_cnt_q[0];
    assign trail_edge_o = tc && edge_cnt_q[0];
    assign last_edge_o  = tc && (edge_cnt_q == EDGE_LAST);
    assign sclk_o       = sclk_q;

    // Next-state: load idle level at transfer start, otherwise count and toggle in XFER
    always_comb begin
        hp_cnt_d   = hp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        if (load_i) begin
            hp_cnt_d   = '0;
            edge_cnt_d = '0;
            sclk_d     = cpol_i;
        end else if (en_i) begin
            if (tc) begin
                hp_cnt_d   = '0;
                edge_cnt_d = edge_cnt_q + 1'b1;
                sclk_d     = ~sclk_q;
            end else begin
                hp_cnt_d = hp_cnt_q + 1'b1;
            end
        end
    end

    // Counter and SCLK registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
        end else begin
            hp_cnt_q   <= hp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - full-duplex SPI master, per-transfer mode, parametrised width/divider/bit order
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 25,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS
);

    import spi_pkg::*;

    if (CLK_DIV < 1 || DATA_W < 2) begin : g_param_check
        $error("spi_master_param: CLK_DIV must be >= 1 and DATA_W >= 2");
    end

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic              mosi_q, mosi_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              gen_load, gen_en;
    logic              lead_edge, trail_edge, last_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    spi_clk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .rst          (rst),
        .load_i       (gen_load),
        .cpol_i       (cpol),
        .en_i         (gen_en),
        .sclk_o       (SCLK),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .last_edge_o  (last_edge)
    );

    assign gen_load = (state_q == IDLE) && start;
    assign gen_en   = (state_q == XFER);

    // Next-state and output decode for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        ph_cnt_d  = ph_cnt_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cs_d = 1'b1;
                if (start) begin
                    mode_d   = '{cpol: cpol, cpha: cpha};
                    cs_d     = 1'b0;
                    busy_d   = 1'b1;
                    ph_cnt_d = '0;
                    state_d  = SETUP;
                    // cpha=0 needs the first bit valid before the first (sampling) edge
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data);
                        tx_sh_d = shift_out(tx_data);
                    end else begin
                        tx_sh_d = tx_data;
                    end
                end
            end

            SETUP: begin
                if (ph_cnt_q == CNT_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = XFER;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end

            XFER: begin
                if (lead_edge) begin
                    if (mode_q.cpha) begin
                        mosi_d  = first_bit(tx_sh_q);
                        tx_sh_d = shift_out(tx_sh_q);
                    end else begin
                        rx_sh_d = shift_in(rx_sh_q, MISO);
                    end
                end
                if (trail_edge) begin
                    if (mode_q.cpha) begin
                        rx_sh_d = shift_in(rx_sh_q, MISO);
                    end else if (!last_edge) begin
                        mosi_d  = first_bit(tx_sh_q);
                        tx_sh_d = shift_out(tx_sh_q);
                    end
                end
                if (last_edge) begin
                    ph_cnt_d = '0;
                    state_d  = HOLD;
                end
            end

            HOLD: begin
                if (ph_cnt_q == CNT_LAST) begin
                    ph_cnt_d  = '0;
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    state_d   = IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= SPI_MODE0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            ph_cnt_q  <= '0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            ph_cnt_q  <= ph_cnt_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign MOSI    = mosi_q;
    assign CS      = cs_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed self-checking bench for spi_master_param
module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpol, cpha;
    logic [7:0] tx_data;

    logic       start0, busy0, done0, sclk0, mosi0, miso0, cs0;
    logic [7:0] rx0;
    logic       start1, busy1, done1, sclk1, mosi1, miso1, cs1;
    logic [7:0] rx1;

    int n_cmp = 0;
    int n_bad = 0;

    logic       sel;
    logic       loop;
    logic       mon_clr;
    logic       mon_cpol, mon_cpha;
    logic [7:0] slv_init;

    int         toggles, dones, cs_low;
    logic [7:0] cap, slv_sh;
    logic       sclk_prev, miso_s;

    logic       m_cs, m_sclk, m_mosi, m_busy, m_done;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .start(start0), .cpol(cpol), .cpha(cpha), .tx_data(tx_data),
        .busy(busy0), .done(done0), .rx_data(rx0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0), .CS(cs0)
    );

    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .start(start1), .cpol(cpol), .cpha(cpha), .tx_data(tx_data),
        .busy(busy1), .done(done1), .rx_data(rx1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .CS(cs1)
    );

    assign miso0  = loop ? mosi0 : miso_s;
    assign miso1  = mosi1;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;

    // Slave model and bus observer, sampled 2 ns after each rising clk edge
    always @(posedge clk) begin
        #2;
        if (mon_clr) begin
            toggles   = 0;
            dones     = 0;
            cap       = 8'h00;
            cs_low    = (m_cs == 1'b0) ? 1 : 0;
            slv_sh    = slv_init;
            sclk_prev = m_sclk;
        end else begin
            if (m_cs == 1'b0) cs_low++;
            if (m_done) dones++;
            if (m_sclk != sclk_prev) begin
                toggles++;
                if (m_sclk == ~(mon_cpol ^ mon_cpha)) begin
                    cap = sel ? {m_mosi, cap[7:1]} : {cap[6:0], m_mosi};
                end else begin
                    miso_s = slv_sh[7];
                    slv_sh = {slv_sh[6:0], 1'b0};
                end
            end
            sclk_prev = m_sclk;
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic s, input logic c_pol, input logic c_pha,
                            input logic [7:0] data, input logic hold);
        sel      = s;
        mon_cpol = c_pol;
        mon_cpha = c_pha;
        cpol     = c_pol;
        cpha     = c_pha;
        tx_data  = data;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        mon_clr  = 1'b1;
        @(negedge clk);
        mon_clr  = 1'b0;
        expect_eq("cs_fall", 32'(m_cs), 0);
        expect_eq("busy_rise", 32'(m_busy), 1);
        if (!hold) begin
            start0 = 1'b0;
            start1 = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!m_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_eq({tag, "_done_seen"}, 32'(m_done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00;
        sel = 1'b0; loop = 1'b1; mon_clr = 1'b0; mon_cpol = 1'b0; mon_cpha = 1'b0;
        slv_init = 8'h00; miso_s = 1'b0;
        repeat (3) @(negedge clk);

        expect_eq("rst_cs", 32'(cs0), 1);
        expect_eq("rst_sclk", 32'(sclk0), 0);
        expect_eq("rst_mosi", 32'(mosi0), 0);
        expect_eq("rst_busy", 32'(busy0), 0);
        expect_eq("rst_done", 32'(done0), 0);
        expect_eq("rst_rx", 32'(rx0), 0);
        expect_eq("rst_rx_lsb", 32'(rx1), 0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, MSB first, loopback
        do_start(1'b0, 1'b0, 1'b0, 8'hD0, 1'b0);
        expect_eq("m0_first_mosi", 32'(mosi0), 1);
        wait_done("m0");
        expect_eq("m0_rx", 32'(rx0), 'hD0);
        expect_eq("m0_mosi_bits", 32'(cap), 'hD0);
        expect_eq("m0_toggles", 32'(toggles), 16);
        expect_eq("m0_cs_low", 32'(cs_low), 36);
        expect_eq("m0_cs_rise", 32'(cs0), 1);
        expect_eq("m0_busy_fall", 32'(busy0), 0);
        @(negedge clk);
        expect_eq("m0_done_width", 32'(done0), 0);
        expect_eq("m0_done_count", 32'(dones), 1);

        // Mode 3, slave drives 0x3C
        loop = 1'b0;
        slv_init = 8'h3C;
        do_start(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        expect_eq("m3_sclk_idle_setup", 32'(sclk0), 1);
        wait_done("m3");
        expect_eq("m3_rx", 32'(rx0), 'h3C);
        expect_eq("m3_slave_saw", 32'(cap), 'hA5);
        expect_eq("m3_toggles", 32'(toggles), 16);
        @(negedge clk);
        expect_eq("m3_sclk_idle_after", 32'(sclk0), 1);
        loop = 1'b1;

        // LSB first, mode 1, loopback
        do_start(1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        wait_done("lsb");
        expect_eq("lsb_rx", 32'(rx1), 'h01);
        expect_eq("lsb_mosi_bits", 32'(cap), 'h01);
        expect_eq("lsb_toggles", 32'(toggles), 16);
        expect_eq("lsb_other_idle", 32'(cs0), 1);
        @(negedge clk);

        // Start re-pulsed mid-transfer must be ignored
        do_start(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        tx_data = 8'hFF; cpol = 1'b1; cpha = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done("mid");
        expect_eq("mid_rx", 32'(rx0), 'h5A);
        expect_eq("mid_mosi_bits", 32'(cap), 'h5A);
        expect_eq("mid_sclk_idle", 32'(sclk0), 0);
        repeat (5) @(negedge clk);
        expect_eq("mid_done_count", 32'(dones), 1);
        expect_eq("mid_cs_idle", 32'(cs0), 1);

        // Reset at the fifth SCLK edge
        do_start(1'b0, 1'b0, 1'b0, 8'h33, 1'b0);
        n = 0;
        while (toggles < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        expect_eq("rst_edge5_reached", 32'(toggles), 5);
        rst = 1'b1;
        @(negedge clk);
        expect_eq("mrst_cs", 32'(cs0), 1);
        expect_eq("mrst_sclk", 32'(sclk0), 0);
        expect_eq("mrst_busy", 32'(busy0), 0);
        expect_eq("mrst_done", 32'(done0), 0);
        expect_eq("mrst_rx", 32'(rx0), 0);
        rst = 1'b0;
        @(negedge clk);
        do_start(1'b0, 1'b0, 1'b0, 8'h96, 1'b0);
        wait_done("post_rst");
        expect_eq("post_rst_rx", 32'(rx0), 'h96);
        expect_eq("post_rst_cs_low", 32'(cs_low), 36);
        @(negedge clk);

        // Back-to-back with start held across done
        do_start(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1);
        wait_done("b2b1");
        expect_eq("b2b1_rx", 32'(rx0), 'h3C);
        tx_data = 8'hC3;
        @(negedge clk);
        expect_eq("b2b_cs_refall", 32'(cs0), 0);
        expect_eq("b2b_done_low", 32'(done0), 0);
        start0 = 1'b0;
        wait_done("b2b2");
        expect_eq("b2b2_rx", 32'(rx0), 'hC3);
        expect_eq("b2b_done_count", 32'(dones), 2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master: full-duplex, all four SPI modes (CPOL/CPHA) selectable per transfer, configurable word width, SCLK divider and bit order. Sits between a local command source (start/tx_data handshake) and one off-chip SPI slave. Replaces the fixed mode-0, 8-bit, TX-only SPI FSM.

Parameters:
DATA_W, 8, bits per transfer (>=2)
CLK_DIV, 25, clk cycles per SCLK half-period (>=1; 25 gives 1 MHz SCLK from 50 MHz clk)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous reset, active-high
start  input  1  request a transfer; sampled only in IDLE
cpol  input  1  SCLK idle level, latched at start
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start
tx_data  input  DATA_W  word to send, latched at start
busy  output  1  high from the cycle after start is accepted until return to IDLE
done  output  1  one-cycle pulse at end of transfer
rx_data  output  DATA_W  last received word, valid from done onward, held until next done
SCLK  output  1  SPI clock
MOSI  output  1  master out
MISO  input  1  slave in (already synchronous to SCLK domain; no synchroniser in this block)
CS  output  1  chip select, active-low

Behaviour:
- Reset (any time, including mid-transfer): state=IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, latched cpol/cpha=0, counters=0. No partial rx_data update.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE. All outputs registered.
- IDLE: CS=1, SCLK=latched cpol. start=1 -> latch cpol, cpha, tx_data into shift register; go SETUP. Start is also accepted in the cycle done is high (back-to-back).
- SETUP: CS=0, busy=1, lasts CLK_DIV cycles. When cpha=0, first data bit on MOSI from the first SETUP cycle.
- XFER: half-period counter 0..CLK_DIV-1; on terminal count SCLK toggles and edge counter increments; exactly 2*DATA_W toggles. Odd toggles = leading edges, even = trailing.
- cpha=0: sample MISO on leading edge; shift next MOSI bit on trailing edge (none after last).
- cpha=1: shift MOSI bit on leading edge (first bit on first leading edge); sample MISO on trailing edge.
- After toggle 2*DATA_W, SCLK is back at cpol; go HOLD.
- HOLD: CS stays 0 for CLK_DIV cycles, MOSI holds last bit. Then CS=1, busy=0, rx_data<=receive shift register, done=1 for one cycle, state IDLE.
- Bit order: MSB_FIRST=1 -> tx_data[DATA_W-1] first and first received bit lands in rx_data[DATA_W-1]; MSB_FIRST=0 mirrors.
- Timing: start accepted at cycle 0 -> CS falls at cycle 1; CS low for (2*DATA_W+2)*CLK_DIV cycles; done coincident with CS rise.
- start, cpol, cpha, tx_data changes while busy are ignored.
- Counter widths: $clog2(CLK_DIV), $clog2(2*DATA_W+1); no wrap inside a transfer.
- Elaboration-time assertion: CLK_DIV>=1, DATA_W>=2.

Decomposition:
- spi_pkg: typedef enum logic [1:0] spi_state_t {IDLE, SETUP, XFER, HOLD}; typedef struct packed {cpol, cpha} spi_mode_t; mode constants SPI_MODE0..SPI_MODE3.
- Sub-module spi_clk_gen: half-period counter and SCLK toggle, outputs lead_edge/trail_edge strobes and last_edge, enabled only in XFER.

Test Plan:
- DATA_W=8, CLK_DIV=2, mode 0, tx_data=0xD0, MISO looped to MOSI -> MOSI bits 1,1,0,1,0,0,0,0 on rising edges; 16 SCLK toggles; CS low 36 cycles; rx_data=0xD0; done one cycle.
- Mode 3 (cpol=1,cpha=1), tx_data=0xA5, MISO driven 0x3C by slave model -> SCLK idles high, slave sees 0xA5 on rising edges, rx_data=0x3C.
- MSB_FIRST=0, mode 1, tx_data=0x01 -> first MOSI bit 1 then seven 0s; loopback rx_data=0x01.
- start pulsed again mid-transfer with tx_data=0xFF -> ignored; only one done; rx_data equals first word.
- rst asserted at edge 5 of a transfer -> next cycle CS=1, SCLK=0, busy=0, done=0, rx_data=0; fresh start afterwards completes normally.
- start held high across done -> second CS fall one cycle after done; two done pulses, rx_data updated each.
